data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
- Responder end of the CPU data SRAM port: accepts en/we/addr/wdata from the core and returns registered rdata one cycle later.
- Backs a word-addressed RAM window plus a small MMIO register page: LED, numeric display, free-running timer, and a bad-address capture register.
- Sits directly on the core's data_sram_* outputs in the SoC top, replacing the black-box data RAM.

Parameters:
- MEM_WORDS_LOG2, 14, log2 of RAM depth in 32-bit words (default 64 KiB).
- MEM_BASE, 32'h1c00_0000, RAM window base; must be aligned to 4*2^MEM_WORDS_LOG2.
- MMIO_BASE, 32'hbfaf_0000, MMIO page base; compare uses bits [31:16] only.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sram_en  in  1  request valid this cycle.
- sram_we  in  4  byte write enables; 0 = read, nonzero = write.
- sram_addr  in  32  byte address; addr[1:0] ignored.
- sram_wdata  in  32  write data, byte lane i = bits [8i+7:8i].
- sram_rdata  out  32  read data, valid the cycle after a read request.
- led  out  16  LED register.
- num_data  out  32  numeric display register.
- bad_access  out  1  sticky flag: a request hit neither window.

Behaviour:
- Reset (resetn=0, async): sram_rdata=0, led=0, num_data=0, timer=0, badaddr=0, bad_access=0. RAM contents are not reset.
- Decode, priority order:
  - mem_hit = sram_addr[31:MEM_WORDS_LOG2+2] == MEM_BASE[31:MEM_WORDS_LOG2+2].
  - mmio_hit = sram_addr[31:16] == MMIO_BASE[31:16].
  - otherwise miss.
- RAM:
  - word index = sram_addr[MEM_WORDS_LOG2+1:2].
  - Write updates only the enabled byte lanes.
  - Read: sram_rdata <= mem[index] at the edge after the request; latency exactly 1.
  - Back-to-back requests every cycle are supported. A read in cycle N+1 of a word written in cycle N returns the new data.
- MMIO, selected by offset sram_addr[15:0]; writes honour byte enables:
  - 0x0000 LED: bits [15:0] writable. Reads return {16'b0, led}.
  - 0x0010 NUM: 32-bit read/write.
  - 0x0020 TIMER: 32-bit, increments by 1 every cycle and wraps FFFF_FFFF -> 0.
    - On a write cycle, timer <= merge(current value, wdata, we); no increment that cycle. Write beats increment.
    - A read returns the timer value sampled in the request cycle.
  - 0x0030 BADADDR: read-only capture of the last miss address. Any write to this offset clears bad_access; badaddr is kept.
  - Any other offset: reads 0, writes ignored, not a miss.
- Miss:
  - Read returns sram_rdata=0 next cycle.
  - Write is dropped.
  - In either case bad_access <= 1 and badaddr <= sram_addr.
- sram_en=0: no state change except the timer increment. sram_rdata holds its last value.
- Write cycles (we!=0): sram_rdata holds its previous value; the core must not sample it.
- Reset asserted mid-request: the request is discarded and all registers return to reset values immediately. RAM may keep a partial write only if the edge preceded reset.
- Single port: at most one request per cycle. A clear and a new miss can never coincide.

Test Plan:
1. After reset release: read MEM_BASE+0x10 after writing 32'hdeadbeef with we=4'hf the previous cycle -> sram_rdata=32'hdeadbeef exactly 1 cycle after the read request.
2. Write 32'h11223344 we=4'hf to MEM_BASE, then 32'haabbccdd we=4'b0101 -> read returns 32'h11bb33dd.
3. Write 32'h0000_1234 to MMIO_BASE+0x0 -> led=16'h1234 next cycle. Write 32'hcafe_f00d we=4'b1100 to +0x10 -> num_data=32'hcafe_0000.
4. Write 32'hffff_fffe to TIMER, idle 3 cycles, read TIMER -> sram_rdata=32'h0000_0001 (wrap). A read in the write cycle+1 returns 32'hffff_fffe.
5. Read 32'h0000_0040 (miss) -> sram_rdata=0, bad_access=1, BADADDR reads 32'h0000_0040. Write to +0x30 -> bad_access=0, BADADDR unchanged.
6. Assert resetn=0 mid-stream with led=16'h00ff and timer running -> led, num_data, sram_rdata and bad_access all 0 before the next clock edge. Timer restarts from 0 after release.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM window plus an MMIO page (LED, numeric display,
// free-running timer, bad-address capture). Read data is registered, latency one cycle.
module data_sram_responder #(
  parameter int          MEM_WORDS_LOG2 = 14,
  parameter logic [31:0] MEM_BASE       = 32'h1c00_0000,
  parameter logic [31:0] MMIO_BASE      = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic        bad_access
);

  localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
  localparam int TAGLSB = MEM_WORDS_LOG2 + 2;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_NUM     = 16'h0010;
  localparam logic [15:0] OFF_TIMER   = 16'h0020;
  localparam logic [15:0] OFF_BADADDR = 16'h0030;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_num;
  logic [31:0] r_timer;
  logic [31:0] r_badaddr;
  logic        r_bad;

  logic                      w_mem_hit;
  logic                      w_mmio_hit;
  logic                      w_wr;
  logic                      w_rd;
  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic [15:0]               w_off;
  logic [31:0]               w_wmask;
  logic [31:0]               w_mmio_rdata;

  // RAM window wins over MMIO if a parameter choice ever makes them overlap
  assign w_mem_hit  = sram_addr[31:TAGLSB] == MEM_BASE[31:TAGLSB];
  assign w_mmio_hit = !w_mem_hit && (sram_addr[31:16] == MMIO_BASE[31:16]);
  assign w_wr       = sram_en && (sram_we != 4'b0000);
  assign w_rd       = sram_en && (sram_we == 4'b0000);
  assign w_idx      = sram_addr[TAGLSB-1:2];
  assign w_off      = sram_addr[15:0];
  assign w_wmask    = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};

  always_comb begin
    w_mmio_rdata = 32'h0;
    case (w_off)
      OFF_LED:     w_mmio_rdata = {16'h0, r_led};
      OFF_NUM:     w_mmio_rdata = r_num;
      OFF_TIMER:   w_mmio_rdata = r_timer;
      OFF_BADADDR: w_mmio_rdata = r_badaddr;
      default:     w_mmio_rdata = 32'h0;
    endcase
  end

  // RAM array carries no reset so it can map onto a block RAM
  always_ff @(posedge clk) begin
    if (w_wr && w_mem_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) r_mem[w_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata   <= 32'h0;
      r_led     <= 16'h0;
      r_num     <= 32'h0;
      r_timer   <= 32'h0;
      r_badaddr <= 32'h0;
      r_bad     <= 1'b0;
    end else begin
      r_timer <= r_timer + 32'd1;
      if (sram_en) begin
        if (w_mem_hit) begin
          if (w_rd) r_rdata <= r_mem[w_idx];
        end else if (w_mmio_hit) begin
          if (w_rd) begin
            r_rdata <= w_mmio_rdata;
          end else begin
            case (w_off)
              OFF_LED:     r_led   <= (r_led & ~w_wmask[15:0]) | (sram_wdata[15:0] & w_wmask[15:0]);
              OFF_NUM:     r_num   <= (r_num & ~w_wmask) | (sram_wdata & w_wmask);
              OFF_TIMER:   r_timer <= (r_timer & ~w_wmask) | (sram_wdata & w_wmask);
              OFF_BADADDR: r_bad   <= 1'b0;
              default:     ;
            endcase
          end
        end else begin
          r_bad     <= 1'b1;
          r_badaddr <= sram_addr;
          if (w_rd) r_rdata <= 32'h0;
        end
      end
    end
  end

  assign sram_rdata = r_rdata;
  assign led        = r_led;
  assign num_data   = r_num;
  assign bad_access = r_bad;

endmodule
